alien_table_writer: RTL and testbench

//  Owns the per-quadrant alien object table that layer_object renders from.

---
 rtl/alien_table_writer_pkg.sv | 32 +++
 rtl/alien_table_writer_if.sv | 24 ++
 rtl/alien_slot_step.sv | 41 ++++
 rtl/alien_table_writer.sv | 150 +++++++++++++++
 tb/tb_alien_table_writer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/alien_table_writer_pkg.sv
// rtl/alien_table_writer_pkg.sv - shared alien object table types and constants
package alien_table_writer_pkg;

  localparam int OBJ_LIMIT = 16;
  localparam int IDX_W     = 4;
  localparam int TIMER_W   = 4;
  localparam int CNT_W     = 8;

  localparam logic [1:0] FRAME_ALIVE0   = 2'd0;
  localparam logic [1:0] FRAME_ALIVE1   = 2'd1;
  localparam logic [1:0] FRAME_EXPLODE0 = 2'd2;
  localparam logic [1:0] FRAME_EXPLODE1 = 2'd3;

  typedef struct packed {
    logic       _valid;
    logic [3:0] _r;
    logic [7:0] _theta;
    logic [1:0] _type;
    logic [1:0] _frame_num;
  } AlienData;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_COMMIT = 2'd2
  } sweep_state_t;

  function automatic logic is_alive(input AlienData s);
    return s._valid && (s._frame_num <= FRAME_ALIVE1);
  endfunction

endpackage

// File: rtl/alien_table_writer_if.sv
// rtl/alien_table_writer_if.sv - spawn/kill request handshakes between game logic and the table
interface alien_table_writer_if;
  import alien_table_writer_pkg::*;

  logic             spawn_valid;
  logic             spawn_ready;
  logic [1:0]       spawn_type;
  logic [7:0]       spawn_theta;
  logic             kill_valid;
  logic             kill_ready;
  logic [IDX_W-1:0] kill_idx;
  logic             kill_hit;

  modport master (
    output spawn_valid, spawn_type, spawn_theta, kill_valid, kill_idx,
    input  spawn_ready, kill_ready, kill_hit
  );

  modport slave (
    input  spawn_valid, spawn_type, spawn_theta, kill_valid, kill_idx,
    output spawn_ready, kill_ready, kill_hit
  );

endinterface

// File: rtl/alien_slot_step.sv
// rtl/alien_slot_step.sv - combinational per-frame advance of one alien slot
module alien_slot_step
  import alien_table_writer_pkg::*;
#(
  parameter int EXPLODE_FRAMES = 6
) (
  input  AlienData             i_slot,
  input  logic [TIMER_W-1:0]   i_timer,
  input  logic                 i_step_due,
  input  logic                 i_anim_due,
  output AlienData             o_slot,
  output logic [TIMER_W-1:0]   o_timer,
  output logic                 o_breach
);

  always_comb begin
    o_slot   = i_slot;
    o_timer  = i_timer;
    o_breach = 1'b0;
    if (i_slot._valid) begin
      if (i_slot._frame_num <= FRAME_ALIVE1) begin
        if (i_step_due && (i_slot._r == 4'd0)) begin
          o_slot   = '0;
          o_timer  = '0;
          o_breach = 1'b1;
        end else begin
          if (i_step_due) o_slot._r = i_slot._r - 4'd1;
          if (i_anim_due) o_slot._frame_num = i_slot._frame_num ^ 2'b01;
        end
      end else if (i_timer == TIMER_W'(EXPLODE_FRAMES - 1)) begin
        // Final tick of an explosion frame: advance to the next frame or free the slot
        o_timer = '0;
        if (i_slot._frame_num == FRAME_EXPLODE0) o_slot._frame_num = FRAME_EXPLODE1;
        else                                     o_slot = '0;
      end else begin
        o_timer = i_timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/alien_table_writer.sv
// rtl/alien_table_writer.sv - owns the alien shadow table, sweeps it once per frame, publishes it
module alien_table_writer
  import alien_table_writer_pkg::*;
#(
  parameter int STEP_FRAMES    = 4,
  parameter int ANIM_FRAMES    = 8,
  parameter int EXPLODE_FRAMES = 6
) (
  input  logic                 clk_100MHz,
  input  logic                 rst,
  input  logic                 frame_tick,
  alien_table_writer_if.slave  bus,
  output logic                 breach,
  output logic                 tick_overrun,
  output logic [4:0]           alive_count,
  output AlienData             obj_data [0:OBJ_LIMIT-1]
);

  sweep_state_t       r_state, w_state_nxt;
  AlienData           r_shadow [0:OBJ_LIMIT-1];
  logic [TIMER_W-1:0] r_timer  [0:OBJ_LIMIT-1];
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_step_cnt, r_anim_cnt;
  logic               r_step_due, r_anim_due;
  logic               r_breach, r_overrun, r_kill_hit;
  logic [4:0]         r_alive;

  logic               w_start, w_sweep_en, w_commit_en, w_idle_open;
  logic               w_free_found;
  logic [IDX_W-1:0]   w_free_idx;
  logic               w_spawn_fire, w_kill_fire;
  logic               w_step_wrap, w_anim_wrap;
  AlienData           w_slot_nxt;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic               w_slot_breach;

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_sweep_en  = 1'b0;
    w_commit_en = 1'b0;
    w_idle_open = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idle_open = !frame_tick;
        if (frame_tick) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        w_sweep_en = 1'b1;
        if (r_idx == IDX_W'(OBJ_LIMIT - 1)) w_state_nxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_commit_en = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Descending scan so the lowest free slot wins
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = OBJ_LIMIT - 1; i >= 0; i--) begin
      if (!r_shadow[i]._valid) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign bus.spawn_ready = !rst && w_idle_open && w_free_found;
  assign bus.kill_ready  = !rst && w_idle_open;
  assign bus.kill_hit    = r_kill_hit;
  assign w_spawn_fire    = bus.spawn_valid && bus.spawn_ready;
  assign w_kill_fire     = bus.kill_valid && bus.kill_ready;
  assign w_step_wrap     = (r_step_cnt == CNT_W'(STEP_FRAMES - 1));
  assign w_anim_wrap     = (r_anim_cnt == CNT_W'(ANIM_FRAMES - 1));

  alien_slot_step #(.EXPLODE_FRAMES(EXPLODE_FRAMES)) u_slot_step (
    .i_slot     (r_shadow[r_idx]),
    .i_timer    (r_timer[r_idx]),
    .i_step_due (r_step_due),
    .i_anim_due (r_anim_due),
    .o_slot     (w_slot_nxt),
    .o_timer    (w_timer_nxt),
    .o_breach   (w_slot_breach)
  );

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      r_shadow   <= '{default: '0};
      r_timer    <= '{default: '0};
      obj_data   <= '{default: '0};
      r_idx      <= '0;
      r_step_cnt <= '0;
      r_anim_cnt <= '0;
      r_step_due <= 1'b0;
      r_anim_due <= 1'b0;
      r_alive    <= '0;
      r_breach   <= 1'b0;
      r_overrun  <= 1'b0;
      r_kill_hit <= 1'b0;
    end else begin
      r_breach   <= 1'b0;
      r_kill_hit <= 1'b0;
      r_overrun  <= frame_tick && (r_state != ST_IDLE);
      if (w_start) begin
        r_idx      <= '0;
        r_step_due <= w_step_wrap;
        r_anim_due <= w_anim_wrap;
        r_step_cnt <= w_step_wrap ? '0 : r_step_cnt + CNT_W'(1);
        r_anim_cnt <= w_anim_wrap ? '0 : r_anim_cnt + CNT_W'(1);
      end
      if (w_sweep_en) begin
        r_shadow[r_idx] <= w_slot_nxt;
        r_timer[r_idx]  <= w_timer_nxt;
        r_breach        <= w_slot_breach;
        r_idx           <= r_idx + IDX_W'(1);
        if (r_shadow[r_idx]._valid && !w_slot_nxt._valid) r_alive <= r_alive - 5'd1;
      end
      if (w_commit_en) obj_data <= r_shadow;
      // Spawn targets a free slot and kill an alive one, so they never collide
      if (w_spawn_fire) begin
        r_shadow[w_free_idx] <= '{_valid: 1'b1, _r: 4'd15, _theta: bus.spawn_theta,
                                  _type: bus.spawn_type, _frame_num: FRAME_ALIVE0};
        r_timer[w_free_idx]  <= '0;
        r_alive              <= r_alive + 5'd1;
      end
      if (w_kill_fire && is_alive(r_shadow[bus.kill_idx])) begin
        r_shadow[bus.kill_idx]._frame_num <= FRAME_EXPLODE0;
        r_timer[bus.kill_idx]             <= '0;
        r_kill_hit                        <= 1'b1;
      end
    end
  end

  assign breach       = r_breach;
  assign tick_overrun = r_overrun;
  assign alive_count  = r_alive;

endmodule

// File: tb/tb_alien_table_writer.sv
// tb/tb_alien_table_writer.sv - directed self-checking bench for alien_table_writer
module tb_alien_table_writer;
  import alien_table_writer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       breach, tick_overrun;
  logic [4:0] alive_count;
  AlienData   obj_data [0:OBJ_LIMIT-1];
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         breach_cnt = 0;

  alien_table_writer_if u_if ();

  alien_table_writer dut (
    .clk_100MHz   (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .bus          (u_if),
    .breach       (breach),
    .tick_overrun (tick_overrun),
    .alive_count  (alive_count),
    .obj_data     (obj_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (breach === 1'b1) breach_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    u_if.spawn_valid = 1'b0; u_if.spawn_type = '0; u_if.spawn_theta = '0;
    u_if.kill_valid = 1'b0;  u_if.kill_idx = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (17) @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input logic [1:0] t, input logic [7:0] th);
    @(negedge clk);
    u_if.spawn_valid = 1'b1; u_if.spawn_type = t; u_if.spawn_theta = th;
    @(posedge clk); #1 u_if.spawn_valid = 1'b0;
  endtask

  task automatic do_kill(input logic [3:0] idx, output logic hit);
    @(negedge clk);
    u_if.kill_valid = 1'b1; u_if.kill_idx = idx;
    @(posedge clk); #1 u_if.kill_valid = 1'b0;
    hit = u_if.kill_hit;
  endtask

  task automatic test_reset();
    int nz;
    rst = 1'b1;
    frame_tick = 1'b0;
    u_if.spawn_valid = 1'b0; u_if.spawn_type = '0; u_if.spawn_theta = '0;
    u_if.kill_valid = 1'b0;  u_if.kill_idx = '0;
    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int i = 0; i < OBJ_LIMIT; i++) if (obj_data[i] !== '0) nz++;
    total_cnt++; if (nz !== 0) $display("FAIL reset_obj_data: got %0d nonzero slots want 0", nz); else pass_cnt++;
    total_cnt++; if ({breach, tick_overrun, alive_count, u_if.kill_hit, u_if.spawn_ready, u_if.kill_ready} !== 10'd0)
      $display("FAIL reset_outputs: got %b want 0", {breach, tick_overrun, alive_count, u_if.kill_hit, u_if.spawn_ready, u_if.kill_ready});
    else pass_cnt++;
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++; if ({u_if.spawn_ready, u_if.kill_ready} !== 2'b11)
      $display("FAIL reset_release_ready: got %b want 11", {u_if.spawn_ready, u_if.kill_ready}); else pass_cnt++;
  endtask

  task automatic test_spawn_publish();
    AlienData exp;
    exp = '{_valid: 1'b1, _r: 4'd15, _theta: 8'h40, _type: 2'd2, _frame_num: 2'd0};
    do_spawn(2'd2, 8'h40);
    total_cnt++; if (alive_count !== 5'd1) $display("FAIL spawn_alive: got %0d want 1", alive_count); else pass_cnt++;
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    total_cnt++; if (u_if.spawn_ready !== 1'b0) $display("FAIL sweep_spawn_ready: got %b want 0", u_if.spawn_ready); else pass_cnt++;
    repeat (16) @(posedge clk); #1;
    total_cnt++; if (obj_data[0] !== '0) $display("FAIL publish_early: got %h want 0", obj_data[0]); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (obj_data[0] !== exp) $display("FAIL publish_slot0: got %h want %h", obj_data[0], exp); else pass_cnt++;
    total_cnt++; if (obj_data[1] !== '0) $display("FAIL publish_slot1: got %h want 0", obj_data[1]); else pass_cnt++;
  endtask

  task automatic test_kill_explode();
    logic hit;
    do_spawn(2'd1, 8'h10);
    do_spawn(2'd0, 8'h20);
    do_spawn(2'd3, 8'h30);
    total_cnt++; if (alive_count !== 5'd4) $display("FAIL kill_pre_alive: got %0d want 4", alive_count); else pass_cnt++;
    do_kill(4'd3, hit);
    total_cnt++; if (hit !== 1'b1) $display("FAIL kill_hit_alive: got %b want 1", hit); else pass_cnt++;
    do_tick();
    total_cnt++; if ({obj_data[3]._valid, obj_data[3]._frame_num} !== 3'b110)
      $display("FAIL kill_frame2: got %b want 110", {obj_data[3]._valid, obj_data[3]._frame_num}); else pass_cnt++;
    repeat (3) do_tick();
    total_cnt++; if (obj_data[0]._r !== 4'd14) $display("FAIL step_r14: got %0d want 14", obj_data[0]._r); else pass_cnt++;
    total_cnt++; if (obj_data[3]._frame_num !== 2'd2) $display("FAIL explode_hold2: got %0d want 2", obj_data[3]._frame_num); else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic     hit;
    AlienData exp;
    exp = '{_valid: 1'b1, _r: 4'd15, _theta: 8'h99, _type: 2'd1, _frame_num: 2'd0};
    @(negedge clk);
    frame_tick = 1'b1;
    u_if.spawn_valid = 1'b1; u_if.spawn_type = 2'd1; u_if.spawn_theta = 8'h99;
    #1;
    total_cnt++; if ({u_if.spawn_ready, u_if.kill_ready} !== 2'b00)
      $display("FAIL tick_blocks_ready: got %b want 00", {u_if.spawn_ready, u_if.kill_ready}); else pass_cnt++;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    total_cnt++; if (tick_overrun !== 1'b1) $display("FAIL overrun_pulse: got %b want 1", tick_overrun); else pass_cnt++;
    repeat (12) @(posedge clk); #1;
    total_cnt++; if ({u_if.spawn_ready, alive_count} !== {1'b1, 5'd4})
      $display("FAIL held_spawn_ready: got %b/%0d want 1/4", u_if.spawn_ready, alive_count); else pass_cnt++;
    total_cnt++; if (obj_data[3]._frame_num !== 2'd2) $display("FAIL overrun_single_adv: got %0d want 2", obj_data[3]._frame_num); else pass_cnt++;
    @(posedge clk); #1 u_if.spawn_valid = 1'b0;
    total_cnt++; if (alive_count !== 5'd5) $display("FAIL held_spawn_accept: got %0d want 5", alive_count); else pass_cnt++;
    do_tick();
    total_cnt++; if (obj_data[3]._frame_num !== 2'd3) $display("FAIL explode_frame3: got %0d want 3", obj_data[3]._frame_num); else pass_cnt++;
    total_cnt++; if (obj_data[4] !== exp) $display("FAIL overrun_spawn_slot4: got %h want %h", obj_data[4], exp); else pass_cnt++;
    do_kill(4'd3, hit);
    total_cnt++; if (hit !== 1'b0) $display("FAIL kill_hit_exploding: got %b want 0", hit); else pass_cnt++;
    do_tick();
    total_cnt++; if (obj_data[0]._frame_num !== 2'd1) $display("FAIL anim_toggle: got %0d want 1", obj_data[0]._frame_num); else pass_cnt++;
  endtask

  task automatic test_full();
    logic     hit;
    AlienData exp;
    exp = '{_valid: 1'b1, _r: 4'd15, _theta: 8'h77, _type: 2'd3, _frame_num: 2'd0};
    do_reset();
    for (int i = 0; i < OBJ_LIMIT; i++) do_spawn(i[1:0], 8'(i));
    total_cnt++; if ({u_if.spawn_ready, alive_count} !== {1'b0, 5'd16})
      $display("FAIL full_ready: got %b/%0d want 0/16", u_if.spawn_ready, alive_count); else pass_cnt++;
    @(negedge clk);
    u_if.spawn_valid = 1'b1; u_if.spawn_type = 2'd3; u_if.spawn_theta = 8'h77;
    repeat (3) @(posedge clk); #1;
    total_cnt++; if (alive_count !== 5'd16) $display("FAIL full_no_accept: got %0d want 16", alive_count); else pass_cnt++;
    do_kill(4'd5, hit);
    total_cnt++; if (hit !== 1'b1) $display("FAIL full_kill_hit: got %b want 1", hit); else pass_cnt++;
    repeat (12) do_tick();
    total_cnt++; if ({u_if.spawn_ready, alive_count, obj_data[5]._valid} !== {1'b1, 5'd15, 1'b0})
      $display("FAIL slot5_freed: got %b/%0d/%b want 1/15/0", u_if.spawn_ready, alive_count, obj_data[5]._valid); else pass_cnt++;
    total_cnt++; if (obj_data[4]._r !== 4'd12) $display("FAIL full_r12: got %0d want 12", obj_data[4]._r); else pass_cnt++;
    @(posedge clk); #1 u_if.spawn_valid = 1'b0;
    total_cnt++; if (alive_count !== 5'd16) $display("FAIL refill_alive: got %0d want 16", alive_count); else pass_cnt++;
    do_tick();
    total_cnt++; if (obj_data[5] !== exp) $display("FAIL refill_slot5: got %h want %h", obj_data[5], exp); else pass_cnt++;
  endtask

  task automatic test_breach();
    int b0;
    do_reset();
    do_spawn(2'd0, 8'h55);
    b0 = breach_cnt;
    repeat (63) do_tick();
    total_cnt++; if ({breach_cnt - b0, 28'd0} !== 60'd0 || obj_data[0]._r !== 4'd0 || obj_data[0]._valid !== 1'b1)
      $display("FAIL pre_breach: got %0d pulses r=%0d v=%b want 0 pulses r=0 v=1", breach_cnt - b0, obj_data[0]._r, obj_data[0]._valid);
    else pass_cnt++;
    do_tick();
    total_cnt++; if (breach_cnt - b0 !== 1) $display("FAIL breach_count: got %0d want 1", breach_cnt - b0); else pass_cnt++;
    total_cnt++; if ({obj_data[0]._valid, alive_count} !== 6'd0)
      $display("FAIL breach_cleared: got v=%b alive=%0d want v=0 alive=0", obj_data[0]._valid, alive_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_sweep();
    int nz;
    do_spawn(2'd1, 8'hA0);
    do_spawn(2'd2, 8'hB0);
    do_tick();
    total_cnt++; if (obj_data[1]._valid !== 1'b1) $display("FAIL mid_pre_publish: got %b want 1", obj_data[1]._valid); else pass_cnt++;
    @(negedge clk); frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    nz = 0;
    for (int i = 0; i < OBJ_LIMIT; i++) if (obj_data[i] !== '0) nz++;
    total_cnt++; if (nz !== 0 || alive_count !== 5'd0)
      $display("FAIL mid_reset_clear: got %0d slots alive=%0d want 0 slots alive=0", nz, alive_count); else pass_cnt++;
    @(negedge clk); rst = 1'b0; #1;
    total_cnt++; if ({u_if.spawn_ready, u_if.kill_ready} !== 2'b11)
      $display("FAIL mid_reset_idle: got %b want 11", {u_if.spawn_ready, u_if.kill_ready}); else pass_cnt++;
    repeat (20) @(posedge clk); #1;
    nz = 0;
    for (int i = 0; i < OBJ_LIMIT; i++) if (obj_data[i] !== '0) nz++;
    total_cnt++; if (nz !== 0 || alive_count !== 5'd0)
      $display("FAIL mid_reset_no_publish: got %0d slots alive=%0d want 0 slots alive=0", nz, alive_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_spawn_publish();
    test_kill_explode();
    test_overrun();
    test_full();
    test_breach();
    test_reset_mid_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
